// File: rtl/ex_muldiv.sv
// Iterative 32-cycle multiply/divide unit for the EX stage.
// Holds HI/LO and stalls the front of the pipe while an operation runs.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);
  localparam int DW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    count_q;
  logic             is_div_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             dz_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] orig_q;
  logic [DW-1:0]    acc_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic             accept;
  logic             last;
  logic             sgn;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  logic [WIDTH:0]   mul_sum;
  logic [DW:0]      div_sh;
  logic [WIDTH:0]   div_diff;
  logic [DW-1:0]    acc_step;

  logic [DW-1:0]    prod_neg;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign accept = (state_q == IDLE) & start_i & ~flush_i;
  assign last   = (count_q == CW'(WIDTH - 1));

  assign stall_o = accept | (state_q == RUN);
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  // Operand magnitudes; unsigned ops pass raw values
  assign sgn  = op_i[0];
  assign mag1 = (sgn & data1_i[WIDTH-1]) ? (~data1_i + WIDTH'(1)) : data1_i;
  assign mag2 = (sgn & data2_i[WIDTH-1]) ? (~data2_i + WIDTH'(1)) : data2_i;

  // Shift-add step: opnd_q is the multiplicand, acc low half the multiplier
  assign mul_sum = {1'b0, acc_q[DW-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Restoring step: opnd_q is the divisor, acc is {rem, quot}
  assign div_sh   = {acc_q, 1'b0};
  assign div_diff = div_sh[DW:WIDTH] - {1'b0, opnd_q};

  always_comb begin
    acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    if (is_div_q) begin
      if (!div_diff[WIDTH])
        acc_step = {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
      else
        acc_step = div_sh[DW-1:0];
    end
  end

  assign prod_neg = ~acc_q + DW'(1);
  assign quot     = acc_q[WIDTH-1:0];
  assign rem      = acc_q[DW-1:WIDTH];

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    unique case (1'b1)
      ~is_div_q: begin
        {res_hi, res_lo} = neg_q_q ? prod_neg : acc_q;
      end
      is_div_q & dz_q: begin
        res_hi = orig_q;
        res_lo = '1;
      end
      is_div_q & ~dz_q: begin
        res_hi = neg_r_q ? (~rem + WIDTH'(1)) : rem;
        res_lo = neg_q_q ? (~quot + WIDTH'(1)) : quot;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q  <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= '0;
      orig_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        count_q  <= '0;
        is_div_q <= op_i[1];
        neg_q_q  <= sgn & (data1_i[WIDTH-1] ^ data2_i[WIDTH-1]);
        neg_r_q  <= sgn & data1_i[WIDTH-1];
        dz_q     <= op_i[1] & ~|data2_i;
        opnd_q   <= op_i[1] ? mag2 : mag1;
        orig_q   <= data1_i;
        acc_q    <= {{WIDTH{1'b0}}, (op_i[1] ? mag1 : mag2)};
      end else if (!flush_i && state_q == RUN) begin
        acc_q   <= acc_step;
        count_q <= count_q + CW'(1);
      end else if (!flush_i && state_q == DONE) begin
        hi_q   <= res_hi;
        lo_q   <= res_lo;
        done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed table, flush/reset sequences,
// and random operations against an arithmetic reference model.
module tb_ex_muldiv;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int vectors = 0;
  int miscompares = 0;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (start_i),
    .op_i    (op_i),
    .data1_i (data1_i),
    .data2_i (data2_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    int qa, qb;
    case (op)
      2'b00: return {32'b0, a} * {32'b0, b};
      2'b01: begin
        sa = $signed(a);
        sb = $signed(b);
        return 64'(sa * sb);
      end
      default: begin
        if (b == 0) return {a, 32'hffffffff};
        if (op == 2'b10) return {a % b, a / b};
        if (a == 32'h80000000 && b == 32'hffffffff)
          return {32'h0, 32'h80000000};
        qa = $signed(a);
        qb = $signed(b);
        return {32'(qa % qb), 32'(qa / qb)};
      end
    endcase
  endfunction

  // Caller sits just after a falling edge; returns just after one.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh,
                       input logic [31:0] el, input string tag);
    int st, bz, dc;
    st = 0;
    bz = 0;
    dc = -1;
    start_i = 1'b1;
    op_i    = op;
    data1_i = a;
    data2_i = b;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (done_o) begin
        dc = c;
        break;
      end
      if (stall_o) st++;
      if (busy_o) bz++;
      @(negedge clk_i);
      if (c == 0) begin
        data1_i = $urandom;
        data2_i = $urandom;
      end
    end
    start_i = 1'b0;
    check({tag, " done_cycle"}, 64'(dc), 64'd34);
    check({tag, " stall_cycles"}, 64'(st), 64'd33);
    check({tag, " busy_cycles"}, 64'(bz), 64'd33);
    check({tag, " hi"}, {32'b0, hi_o}, {32'b0, eh});
    check({tag, " lo"}, {32'b0, lo_o}, {32'b0, el});
    @(negedge clk_i);
    #1;
    check({tag, " done_pulse_end"}, {63'b0, done_o}, 64'd0);
  endtask

  initial begin
    logic [63:0] exp;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    tbl[0]  = '{2'b00, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001, "multu_max"};
    tbl[1]  = '{2'b01, 32'hfffffffd, 32'd7, 32'hffffffff, 32'hffffffeb, "mult_neg3x7"};
    tbl[2]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, "mult_min_sq"};
    tbl[3]  = '{2'b11, 32'hfffffff9, 32'd2, 32'hffffffff, 32'hfffffffd, "div_neg7_2"};
    tbl[4]  = '{2'b10, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7"};
    tbl[5]  = '{2'b11, 32'h80000000, 32'hffffffff, 32'h0, 32'h80000000, "div_ovf"};
    tbl[6]  = '{2'b10, 32'd100, 32'd0, 32'd100, 32'hffffffff, "divu_by0"};
    tbl[7]  = '{2'b11, 32'hfffffffb, 32'd0, 32'hfffffffb, 32'hffffffff, "div_neg5_by0"};
    tbl[8]  = '{2'b11, 32'd7, 32'hfffffffe, 32'd1, 32'hfffffffd, "div_7_neg2"};
    tbl[9]  = '{2'b01, 32'd0, 32'hffffffff, 32'h0, 32'h0, "mult_zero"};
    tbl[10] = '{2'b00, 32'd2, 32'd3, 32'h0, 32'd6, "multu_2x3"};

    rst_n_i = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = 2'b00;
    data1_i = '0;
    data2_i = '0;
    #12;
    check("reset hi", {32'b0, hi_o}, 64'd0);
    check("reset lo", {32'b0, lo_o}, 64'd0);
    check("reset flags", {61'b0, done_o, busy_o, stall_o}, 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    foreach (tbl[i])
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].name);

    // Flush a DIVU at count 10; HI/LO keep the 2x3 result
    start_i = 1'b1;
    op_i    = 2'b10;
    data1_i = 32'd1000;
    data2_i = 32'd7;
    repeat (11) @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    check("flush busy_before", {63'b0, busy_o}, 64'd1);
    @(negedge clk_i);
    #1;
    check("flush state", {61'b0, done_o, busy_o, stall_o}, 64'd0);
    check("flush hilo", {hi_o, lo_o}, {32'd0, 32'd6});
    flush_i = 1'b0;
    do_op(2'b00, 32'd5, 32'd6, 32'd0, 32'd30, "after_flush");

    // Asynchronous reset in the middle of a RUN
    start_i = 1'b1;
    op_i    = 2'b01;
    data1_i = 32'd9;
    data2_i = 32'd9;
    repeat (5) @(negedge clk_i);
    #2 start_i = 1'b0;
    #1 rst_n_i = 1'b0;
    #1;
    check("midrun_reset hilo", {hi_o, lo_o}, 64'd0);
    check("midrun_reset flags", {61'b0, done_o, busy_o, stall_o}, 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    #1;
    check("post_reset flags", {61'b0, done_o, busy_o, stall_o}, 64'd0);

    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin
          ra = 32'h80000000;
          rb = 32'hffffffff;
        end
        2: begin
          ra = 32'($urandom_range(0, 300)) - 32'd150;
          rb = 32'($urandom_range(0, 20)) - 32'd10;
        end
        default: ;
      endcase
      exp = ref_model(rop, ra, rb);
      do_op(rop, ra, rb, exp[63:32], exp[31:0], $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
